lsu_mem_initiator: RTL and testbench

Load/store initiator that sits in the RV32I core's memory stage and drives the data-RAM controller port (word address, write data, write enable, byteEn/halfEn/wordEn/unsignedEn, one-cycle-latency read data). The RAM controller's sub-word write strobes always target lane 0, so this block performs all byte-lane handling. Sub-word stores at non-zero offsets become read-modify-write sequences. Loads are issued as word reads and then aligned and extended locally. It presents a valid/ready request and a pulsed response to the pipeline.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_mem_initiator_if.sv | 38 +++
 rtl/lsu_load_align.sv | 42 ++++
 rtl/lsu_mem_initiator.sv | 154 +++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator: FSM states, access
// sizes, RV32I funct3 codes and the size/offset decode used at acceptance.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    LD_RSP,
    ST,
    RMW_RD,
    RMW_WR,
    FAULT
  } lsuState_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsuSize_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Anything that is not a byte or halfword code (including 011/110/111) is a word.
  function automatic lsuSize_t decodeSize(input logic [2:0] funct3);
    lsuSize_t size;
    case (funct3)
      F3_LB, F3_LBU: size = SZ_BYTE;
      F3_LH, F3_LHU: size = SZ_HALF;
      default:       size = SZ_WORD;
    endcase
    return size;
  endfunction

  function automatic logic isMisaligned(input lsuSize_t size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) || ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

  // Clears the low address bits a naturally aligned access of this size cannot use.
  function automatic logic [1:0] alignOffset(input lsuSize_t size, input logic [1:0] offset);
    logic [1:0] aligned;
    case (size)
      SZ_BYTE: aligned = offset;
      SZ_HALF: aligned = {offset[1], 1'b0};
      default: aligned = 2'b00;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Pipeline request/response and data-RAM controller port of the load/store
// initiator; master is the initiator's view, slave is the pipeline/RAM side.
interface lsu_mem_initiator_if #(
  parameter int XLEN      = 32,
  parameter int ADDRWIDTH = 12
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic                 rsp_valid;
  logic [XLEN-1:0]      rsp_data;
  logic                 rsp_fault;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [XLEN-1:0]      mem_wrData;
  logic                 mem_wrEn;
  logic                 mem_byteEn;
  logic                 mem_halfEn;
  logic                 mem_wordEn;
  logic                 mem_unsignedEn;
  logic [XLEN-1:0]      mem_dataOut;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataOut,
    output req_ready, rsp_valid, rsp_data, rsp_fault,
           mem_addr, mem_wrData, mem_wrEn, mem_byteEn, mem_halfEn, mem_wordEn, mem_unsignedEn
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataOut,
    input  req_ready, rsp_valid, rsp_data, rsp_fault,
           mem_addr, mem_wrData, mem_wrEn, mem_byteEn, mem_halfEn, mem_wordEn, mem_unsignedEn
  );

endinterface

// File: rtl/lsu_load_align.sv
// Byte-lane handling for a fetched word: extracts and sign/zero-extends a load
// lane, and builds the merged word for a read-modify-write sub-word store.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdWord,
  input  logic [1:0]      offset,
  input  lsuSize_t        size,
  input  logic            isUnsigned,
  input  logic [15:0]     stLow,
  output logic [XLEN-1:0] ldData,
  output logic [XLEN-1:0] mergedWord
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  assign laneByte = rdWord[{offset, 3'b000} +: 8];
  assign laneHalf = rdWord[{offset[1], 4'b0000} +: 16];

  always_comb begin
    ldData     = rdWord;
    mergedWord = rdWord;
    case (size)
      SZ_BYTE: begin
        ldData = {{(XLEN-8){laneByte[7] & ~isUnsigned}}, laneByte};
        mergedWord[{offset, 3'b000} +: 8] = stLow[7:0];
      end
      SZ_HALF: begin
        ldData = {{(XLEN-16){laneHalf[15] & ~isUnsigned}}, laneHalf};
        mergedWord[{offset[1], 4'b0000} +: 16] = stLow;
      end
      default: begin
        ldData     = rdWord;
        mergedWord = rdWord;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// RV32I memory-stage load/store initiator driving a lane-0-only RAM controller.
// Define MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  lsu_mem_initiator_if.master bus
);

  localparam int ADDRWIDTH = $clog2(DEPTH);

  lsuState_t            state;
  logic                 reqReady;
  logic                 rspValid;
  logic                 memWrEn;
  logic [ADDRWIDTH-1:0] memAddr;
  logic [XLEN-1:0]      wrDataReg;
  logic                 byteEn;
  logic                 halfEn;
  logic                 wordEn;
  lsuSize_t             latchedSize;
  logic [1:0]           latchedOffset;
  logic                 latchedUnsigned;

  lsuSize_t             reqSize;
  logic [1:0]           reqOffset;
  logic [XLEN-1:0]      ldData;
  logic [XLEN-1:0]      mergedWord;
  logic                 unusedAddrBits;

  assign reqSize        = decodeSize(bus.req_funct3);
  assign reqOffset      = alignOffset(reqSize, bus.req_addr[1:0]);
  assign unusedAddrBits = ^bus.req_addr[XLEN-1:ADDRWIDTH+2];

`ifdef MISALIGN_TRAP_EN
  logic rspFault;
  logic reqMisaligned;
  assign reqMisaligned = isMisaligned(reqSize, bus.req_addr[1:0]);
`endif

  lsu_load_align #(.XLEN(XLEN)) alignUnit (
    .rdWord     (bus.mem_dataOut),
    .offset     (latchedOffset),
    .size       (latchedSize),
    .isUnsigned (latchedUnsigned),
    .stLow      (wrDataReg[15:0]),
    .ldData     (ldData),
    .mergedWord (mergedWord)
  );

  // All controller strobes and the response pulse are set one edge ahead, so
  // each state's outputs are already registered when the state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      reqReady        <= 1'b1;
      rspValid        <= 1'b0;
      memWrEn         <= 1'b0;
      memAddr         <= '0;
      wrDataReg       <= '0;
      byteEn          <= 1'b0;
      halfEn          <= 1'b0;
      wordEn          <= 1'b1;
      latchedSize     <= SZ_WORD;
      latchedOffset   <= 2'b00;
      latchedUnsigned <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      rspFault        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            reqReady        <= 1'b0;
            memAddr         <= bus.req_addr[ADDRWIDTH+1:2];
            wrDataReg       <= bus.req_wdata;
            latchedSize     <= reqSize;
            latchedOffset   <= reqOffset;
            latchedUnsigned <= bus.req_funct3[2];
`ifdef MISALIGN_TRAP_EN
            if (reqMisaligned) begin
              state    <= FAULT;
              rspValid <= 1'b1;
              rspFault <= 1'b1;
            end else
`endif
            if (!bus.req_we) begin
              state <= LD;
            end else if ((reqSize == SZ_WORD) || (reqOffset == 2'b00)) begin
              // The controller's sub-word strobes hit lane 0, so offset 0 can be written directly.
              state    <= ST;
              memWrEn  <= 1'b1;
              rspValid <= 1'b1;
              byteEn   <= (reqSize == SZ_BYTE);
              halfEn   <= (reqSize == SZ_HALF);
              wordEn   <= (reqSize == SZ_WORD);
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LD: begin
          state    <= LD_RSP;
          rspValid <= 1'b1;
        end
        RMW_RD: begin
          state    <= RMW_WR;
          memWrEn  <= 1'b1;
          rspValid <= 1'b1;
        end
        LD_RSP, ST, RMW_WR, FAULT: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          rspValid <= 1'b0;
          memWrEn  <= 1'b0;
          byteEn   <= 1'b0;
          halfEn   <= 1'b0;
          wordEn   <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          rspFault <= 1'b0;
`endif
        end
        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          rspValid <= 1'b0;
          memWrEn  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready      = reqReady;
  assign bus.rsp_valid      = rspValid;
  assign bus.rsp_data       = (state == LD_RSP) ? ldData : '0;
  assign bus.mem_addr       = memAddr;
  assign bus.mem_wrData     = (state == RMW_WR) ? mergedWord : wrDataReg;
  assign bus.mem_wrEn       = memWrEn;
  assign bus.mem_byteEn     = byteEn;
  assign bus.mem_halfEn     = halfEn;
  assign bus.mem_wordEn     = wordEn;
  assign bus.mem_unsignedEn = 1'b0;

`ifdef MISALIGN_TRAP_EN
  assign bus.rsp_fault = rspFault;
`else
  assign bus.rsp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: vector table plus hand-written
// sequences for reset during read-modify-write and a held-high request.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          expLat;
    logic [31:0] expData;
    logic        expFault;
    int          expWrites;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   wrCount = 0;
  int   byteWrCount = 0;
  bit   ramInit = 1'b0;
  logic [31:0] ram [0:4095];
  vec_t vecs[$];

  always #5 clk = ~clk;

  lsu_mem_initiator_if bus ();

  lsu_mem_initiator #(.XLEN(32), .DEPTH(4096)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM controller model: sub-word writes land in lane 0, reads have one cycle of latency.
  always @(posedge clk) begin
    if (!ramInit) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      ramInit <= 1'b1;
    end else if (bus.mem_wrEn) begin
      wrCount <= wrCount + 1;
      if (bus.mem_wordEn)      ram[bus.mem_addr]        <= bus.mem_wrData;
      else if (bus.mem_halfEn) ram[bus.mem_addr][15:0]  <= bus.mem_wrData[15:0];
      else if (bus.mem_byteEn) begin
        ram[bus.mem_addr][7:0] <= bus.mem_wrData[7:0];
        byteWrCount <= byteWrCount + 1;
      end
    end
    bus.mem_dataOut <= ram[bus.mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int expLat, input logic [31:0] expData,
                        input logic expFault, input int expWrites);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.expLat = expLat; v.expData = expData; v.expFault = expFault; v.expWrites = expWrites;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] data,
                               output logic fault, output logic readyAfter, output int writes);
    int startWr;
    int waitCycles;
    lat = 0; data = '0; fault = 1'b0; readyAfter = 1'b1; writes = 0;
    waitCycles = 0;
    @(negedge clk);
    while (!bus.req_ready && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.req_ready) begin
      checkOutput({v.name, " ready timeout"}, 32'(bus.req_ready), 32'd1);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    startWr        = wrCount;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) readyAfter = bus.req_ready;
      if (bus.rsp_valid) begin
        lat   = n;
        data  = bus.rsp_data;
        fault = bus.rsp_fault;
        break;
      end
    end
    @(negedge clk);
    writes = wrCount - startWr;
  endtask

  task automatic runVec(input vec_t v);
    int          lat;
    logic [31:0] data;
    logic        fault;
    logic        readyAfter;
    int          writes;
    applyStimulus(v, lat, data, fault, readyAfter, writes);
    checkOutput({v.name, " latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({v.name, " data"}, data, v.expData);
    checkOutput({v.name, " fault"}, 32'(fault), 32'(v.expFault));
    checkOutput({v.name, " writes"}, 32'(writes), 32'(v.expWrites));
    checkOutput({v.name, " ready@T+1"}, 32'(readyAfter), 32'd0);
  endtask

  initial begin
    int   startWr;
    int   startByte;
    vec_t v;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    addVec("SW 0x10",       1'b1, F3_SW,  32'h10,    32'hDEADBEEF, 1, 32'h0,        1'b0, 1);
    addVec("LW 0x10",       1'b0, F3_LW,  32'h10,    32'h0,        2, 32'hDEADBEEF, 1'b0, 0);
    addVec("SW 0x10 b",     1'b1, F3_SW,  32'h10,    32'h11223344, 1, 32'h0,        1'b0, 1);
    addVec("SB 0x13 rmw",   1'b1, F3_SB,  32'h13,    32'h00000080, 2, 32'h0,        1'b0, 1);
    addVec("LW 0x10 b",     1'b0, F3_LW,  32'h10,    32'h0,        2, 32'h80223344, 1'b0, 0);
    addVec("LB 0x13",       1'b0, F3_LB,  32'h13,    32'h0,        2, 32'hFFFFFF80, 1'b0, 0);
    addVec("LBU 0x13",      1'b0, F3_LBU, 32'h13,    32'h0,        2, 32'h00000080, 1'b0, 0);
    addVec("LB 0x11",       1'b0, F3_LB,  32'h11,    32'h0,        2, 32'h00000033, 1'b0, 0);
    addVec("LH 0x10",       1'b0, F3_LH,  32'h10,    32'h0,        2, 32'h00003344, 1'b0, 0);
    addVec("SB 0x12 rmw",   1'b1, F3_SB,  32'h12,    32'hFFFFFF5A, 2, 32'h0,        1'b0, 1);
    addVec("LW high bits",  1'b0, F3_LW,  32'h10010, 32'h0,        2, 32'h805A3344, 1'b0, 0);
    addVec("SW 0x20",       1'b1, F3_SW,  32'h20,    32'h00000000, 1, 32'h0,        1'b0, 1);
    addVec("SH 0x22 rmw",   1'b1, F3_SH,  32'h22,    32'h1234BEEF, 2, 32'h0,        1'b0, 1);
    addVec("LW 0x20",       1'b0, F3_LW,  32'h20,    32'h0,        2, 32'hBEEF0000, 1'b0, 0);
    addVec("LH 0x22",       1'b0, F3_LH,  32'h22,    32'h0,        2, 32'hFFFFBEEF, 1'b0, 0);
    addVec("LHU 0x22",      1'b0, F3_LHU, 32'h22,    32'h0,        2, 32'h0000BEEF, 1'b0, 0);
`ifdef MISALIGN_TRAP_EN
    addVec("LW 0x21 mis",   1'b0, F3_LW,  32'h21,    32'h0,        1, 32'h0,        1'b1, 0);
`else
    addVec("LW 0x21 mis",   1'b0, F3_LW,  32'h21,    32'h0,        2, 32'hBEEF0000, 1'b0, 0);
`endif
    addVec("SH 0x20 direct", 1'b1, F3_SH, 32'h20,    32'hAAAA7777, 1, 32'h0,        1'b0, 1);
    addVec("LW 0x20 b",     1'b0, F3_LW,  32'h20,    32'h0,        2, 32'hBEEF7777, 1'b0, 0);
    addVec("LBU 0x21",      1'b0, F3_LBU, 32'h21,    32'h0,        2, 32'h00000077, 1'b0, 0);
`ifdef MISALIGN_TRAP_EN
    addVec("LH 0x23 mis",   1'b0, F3_LH,  32'h23,    32'h0,        1, 32'h0,        1'b1, 0);
`else
    addVec("LH 0x23 mis",   1'b0, F3_LH,  32'h23,    32'h0,        2, 32'hFFFFBEEF, 1'b0, 0);
`endif

    #12;
    checkOutput("reset req_ready",  32'(bus.req_ready),  32'd1);
    checkOutput("reset rsp_valid",  32'(bus.rsp_valid),  32'd0);
    checkOutput("reset rsp_data",   bus.rsp_data,        32'h0);
    checkOutput("reset rsp_fault",  32'(bus.rsp_fault),  32'd0);
    checkOutput("reset mem_wrEn",   32'(bus.mem_wrEn),   32'd0);
    checkOutput("reset mem_addr",   32'(bus.mem_addr),   32'd0);
    checkOutput("reset mem_wrData", bus.mem_wrData,      32'h0);
    checkOutput("reset idle strobes",
                {28'd0, bus.mem_wordEn, bus.mem_halfEn, bus.mem_byteEn, bus.mem_unsignedEn}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) runVec(vecs[i]);

    // Reset while the RMW read of SB @0x11 is in flight must abandon the write.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SB;
    bus.req_addr   = 32'h11;
    bus.req_wdata  = 32'h000000AA;
    startWr        = wrCount;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst mid-RMW wrEn",  32'(bus.mem_wrEn),  32'd0);
    checkOutput("rst mid-RMW ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst mid-RMW rsp",   32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst release ready",  32'(bus.req_ready), 32'd1);
    checkOutput("rst mid-RMW writes", 32'(wrCount - startWr), 32'd0);
    v.name = "LW after rst"; v.we = 1'b0; v.f3 = F3_LW; v.addr = 32'h10; v.wdata = '0;
    v.expLat = 2; v.expData = 32'h805A3344; v.expFault = 1'b0; v.expWrites = 0;
    runVec(v);

    // req_valid held high across a direct SB: exactly one byte write, no re-accept.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SB;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h123456C3;
    startWr        = wrCount;
    startByte      = byteWrCount;
    @(negedge clk);
    checkOutput("held T+1 ready",  32'(bus.req_ready),  32'd0);
    checkOutput("held T+1 rsp",    32'(bus.rsp_valid),  32'd1);
    checkOutput("held T+1 wrEn",   32'(bus.mem_wrEn),   32'd1);
    checkOutput("held T+1 byteEn", 32'(bus.mem_byteEn), 32'd1);
    @(negedge clk);
    checkOutput("held T+2 ready",  32'(bus.req_ready),  32'd1);
    checkOutput("held T+2 rsp",    32'(bus.rsp_valid),  32'd0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("held writes",      32'(wrCount - startWr),       32'd1);
    checkOutput("held byte writes", 32'(byteWrCount - startByte), 32'd1);
    v.name = "LW 0x40"; v.we = 1'b0; v.f3 = F3_LW; v.addr = 32'h40; v.wdata = '0;
    v.expLat = 2; v.expData = 32'h000000C3; v.expFault = 1'b0; v.expWrites = 0;
    runVec(v);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
